cache_cmd_sequencer: RTL and testbench
======================================

// Module: cache_cmd_sequencer
// PURPOSE
// Upstream OBI manager for the cache top: converts one host command (GET/PUT/DEL + key/value)
// into the OBI register-write/poll/read sequence on the cache's OBI subordinate port.
// Returns hit, read data and error to the host.
// Flattened OBI signals; a wrapper packs them into obi_req_t/obi_rsp_t.
// One command in flight; one outstanding OBI transaction.
// PARAMETERS
// KEY_WIDTH    cache_cfg_pkg::KEY_WIDTH    key bits, <=32
// VALUE_WIDTH  cache_cfg_pkg::VALUE_WIDTH  value bits, <=32
// ADDR_WIDTH   32    OBI address width
// BASE_ADDR    'h0   cache register base address
// POLL_LIMIT   64    max STATUS reads before timeout error, >=1
// PORTS
// clk          in   1            clock
// rst_n        in   1            async active-low reset
// cmd_valid_i  in   1            host command valid
// cmd_ready_o  out  1            sequencer idle, accepts command
// cmd_op_i     in   2            1=GET 2=PUT 3=DEL (0 reserved -> error response)
// cmd_key_i    in   KEY_WIDTH    key
// cmd_val_i    in   VALUE_WIDTH  value (PUT only)
// rsp_valid_o  out  1            response valid, held until rsp_ready_i
// rsp_ready_i  in   1            host accepts response
// rsp_hit_o    out  1            STATUS.hit of final poll
// rsp_data_o   out  VALUE_WIDTH  GET data on hit, else 0
// rsp_err_o    out  1            OBI err, timeout or bad op
// obi_req_o    out  1            OBI req
// obi_gnt_i    in   1            OBI gnt
// obi_addr_o   out  ADDR_WIDTH   OBI addr
// obi_we_o     out  1            1=write
// obi_be_o     out  4            byte enables, always 4'hF
// obi_wdata_o  out  32           write data, zero-extended
// obi_rvalid_i in   1            OBI rvalid
// obi_rdata_i  in   32           OBI rdata
// obi_err_i    in   1            OBI err, sampled with rvalid
// BEHAVIOUR
// Register map (BASE_ADDR+): 0x00 OPERATION, 0x04 STATUS{[2]data_valid,[1]hit,[0]busy}, 0x08 KEY,
//   0x0C VALUE_IN, 0x10 VALUE_OUT.
// Reset: state IDLE; cmd_ready_o=1; rsp_valid_o/hit/err=0; rsp_data_o=0; obi_req_o=0;
//   addr/wdata/we=0; poll counter=0.
// Handshake: command captured on cmd_valid_i&cmd_ready_o; cmd_ready_o=1 only in IDLE.
// OBI: req/addr/we/wdata stable from assertion until gnt cycle; req drops the cycle after gnt.
//   Next req only after rvalid of previous (one outstanding); rvalid may coincide with gnt cycle+1 or later.
// FSM: IDLE -> WR_KEY -> (PUT: WR_VAL) -> WR_OP -> POLL -> (GET & hit: RD_DATA) -> RESP -> IDLE.
//   WR_OP writes cmd_op to OPERATION, zero-extended.
//   POLL: read STATUS; busy=1 -> reissue read, counter++; busy=0 -> latch hit, leave POLL.
//   Counter reaching POLL_LIMIT reads with busy still 1 -> RESP, err=1.
//   RD_DATA: read VALUE_OUT, rsp_data_o = rdata[VALUE_WIDTH-1:0].
//   Bad op (0): IDLE -> RESP directly, err=1, no OBI traffic.
// Error: obi_err_i=1 with rvalid in any state -> RESP with err=1; hit=0; data=0.
// RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; IDLE next cycle; counter cleared.
// Min latency (gnt same cycle, rvalid next): DEL/miss-GET 3 transactions+poll; ~7 cycles accept->rsp_valid.
// Reset mid-operation: immediate return to reset values; in-flight OBI response ignored after reset.
// TESTING
// PUT key=0x2A val=0xDEADBEEF, gnt immediate, STATUS busy=0 -> writes 0x08=0x2A, 0x0C=0xDEADBEEF, 0x00=2; rsp hit per STATUS, err=0.
// GET key=0x2A, STATUS busy=1 x3 then 0x2 -> 4 STATUS reads, VALUE_OUT read, rsp_data=0xDEADBEEF, hit=1.
// GET miss (STATUS=0x0) -> no VALUE_OUT read, rsp hit=0 data=0 err=0.
// POLL_LIMIT=4, busy stuck 1 -> exactly 4 STATUS reads, rsp err=1.
// obi_err_i on KEY write -> no further requests, rsp err=1; gnt delayed 5 cycles -> req/addr held stable.
// rsp_ready_i low 10 cycles -> rsp outputs stable, cmd_ready_o=0; rst_n low during POLL -> reset values.

Source files
------------

// File: rtl/cache_cmd_sequencer.sv
// Host-command to OBI sequencer for the cache register block: key/value/op writes,
// STATUS polling and VALUE_OUT readback, with a single outstanding OBI transaction.
module cache_cmd_sequencer #(
  parameter int unsigned            KEY_WIDTH   = 32,
  parameter int unsigned            VALUE_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            POLL_LIMIT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [KEY_WIDTH-1:0]   cmd_key_i,
  input  logic [VALUE_WIDTH-1:0] cmd_val_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [VALUE_WIDTH-1:0] rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]  obi_addr_o,
  output logic                   obi_we_o,
  output logic [3:0]             obi_be_o,
  output logic [31:0]            obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic [31:0]            obi_rdata_i,
  input  logic                   obi_err_i
);

  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  localparam logic [ADDR_WIDTH-1:0] A_OP     = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_KEY    = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_VIN    = BASE_ADDR + ADDR_WIDTH'(12);
  localparam logic [ADDR_WIDTH-1:0] A_VOUT   = BASE_ADDR + ADDR_WIDTH'(16);

  localparam logic [1:0] OP_GET = 2'd1;
  localparam logic [1:0] OP_PUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_KEY, S_WR_VAL, S_WR_OP, S_POLL, S_RD_DATA, S_RESP
  } state_e;

  state_e                 state_q;
  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic                   hit_q;
  logic                   err_q;
  logic [VALUE_WIDTH-1:0] data_q;
  logic                   req_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [31:0]            wdata_q;
  logic                   outst_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [1:0]             op_q;
  logic [VALUE_WIDTH-1:0] val_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      outst_q     <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      val_q       <= '0;
    end else begin
      if (req_q && obi_gnt_i) begin
        req_q   <= 1'b0;
        outst_q <= 1'b1;
      end
      case (state_q)
        // cmd_ready_q is high exactly while idle, so cmd_valid_i alone qualifies capture
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op_i;
            val_q       <= cmd_val_i;
            if (cmd_op_i == 2'd0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
            end else begin
              state_q <= S_WR_KEY;
              req_q   <= 1'b1;
              addr_q  <= A_KEY;
              we_q    <= 1'b1;
              wdata_q <= 32'(cmd_key_i);
            end
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
          end
        end
        default: begin
          if (outst_q && obi_rvalid_i) begin
            outst_q <= 1'b0;
            if (obi_err_i) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
              hit_q       <= 1'b0;
              data_q      <= '0;
            end else begin
              case (state_q)
                S_WR_KEY: begin
                  req_q <= 1'b1;
                  we_q  <= 1'b1;
                  if (op_q == OP_PUT) begin
                    state_q <= S_WR_VAL;
                    addr_q  <= A_VIN;
                    wdata_q <= 32'(val_q);
                  end else begin
                    state_q <= S_WR_OP;
                    addr_q  <= A_OP;
                    wdata_q <= 32'(op_q);
                  end
                end
                S_WR_VAL: begin
                  state_q <= S_WR_OP;
                  req_q   <= 1'b1;
                  addr_q  <= A_OP;
                  we_q    <= 1'b1;
                  wdata_q <= 32'(op_q);
                end
                S_WR_OP: begin
                  state_q <= S_POLL;
                  req_q   <= 1'b1;
                  addr_q  <= A_STATUS;
                  we_q    <= 1'b0;
                  wdata_q <= '0;
                  cnt_q   <= '0;
                end
                S_POLL: begin
                  if (obi_rdata_i[0]) begin
                    if (cnt_d == CNT_W'(POLL_LIMIT)) begin
                      state_q     <= S_RESP;
                      rsp_valid_q <= 1'b1;
                      err_q       <= 1'b1;
                      hit_q       <= 1'b0;
                    end else begin
                      req_q <= 1'b1;
                      cnt_q <= cnt_d;
                    end
                  end else begin
                    hit_q <= obi_rdata_i[1];
                    if (op_q == OP_GET && obi_rdata_i[1]) begin
                      state_q <= S_RD_DATA;
                      req_q   <= 1'b1;
                      addr_q  <= A_VOUT;
                    end else begin
                      state_q     <= S_RESP;
                      rsp_valid_q <= 1'b1;
                    end
                  end
                end
                S_RD_DATA: begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  data_q      <= obi_rdata_i[VALUE_WIDTH-1:0];
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign obi_req_o   = req_q;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = 4'hF;
  assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Scoreboard bench: an OBI subordinate model checks each granted transaction against
// an expected queue, and a response monitor checks host responses against another.
module tb_cache_cmd_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_key;
  logic [31:0] cmd_val;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;

  cache_cmd_sequencer #(
    .KEY_WIDTH  (32),
    .VALUE_WIDTH(32),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0),
    .POLL_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_key_i   (cmd_key),
    .cmd_val_i   (cmd_val),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_hit_o   (rsp_hit),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .obi_req_o   (obi_req),
    .obi_gnt_i   (obi_gnt),
    .obi_addr_o  (obi_addr),
    .obi_we_o    (obi_we),
    .obi_be_o    (obi_be),
    .obi_wdata_o (obi_wdata),
    .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i (obi_rdata),
    .obi_err_i   (obi_err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          txn_count = 0;
  int          rsp_count = 0;
  int          gnt_delay = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] value_out = 32'hDEAD_BEEF;
  txn_t        exp_txn[$];
  rsp_t        exp_rsp[$];
  logic [31:0] status_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // OBI subordinate: grants after gnt_delay cycles, answers one cycle after grant.
  initial begin
    int   gnt_wait = 0;
    logic pend = 1'b0;
    logic pend_err = 1'b0;
    logic [31:0] pend_data = '0;
    txn_t hold, cur, e;
    obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
    forever begin
      @(negedge clk);
      obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
      if (pend) begin
        obi_rvalid = 1'b1; obi_rdata = pend_data; obi_err = pend_err; pend = 1'b0;
      end
      if (!rst_n || !obi_req) begin
        gnt_wait = 0;
      end else begin
        cur = '{obi_addr, obi_we, obi_wdata};
        if (gnt_wait == 0) hold = cur;
        else chk("req_stable", 96'(cur), 96'(hold));
        if (gnt_wait < gnt_delay) begin
          gnt_wait++;
        end else begin
          obi_gnt = 1'b1;
          gnt_wait = 0;
          txn_count++;
          chk("be", 96'(obi_be), 96'(4'hF));
          if (exp_txn.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req: got addr %0h we %0b wdata %0h, required no request",
                     obi_addr, obi_we, obi_wdata);
          end else begin
            e = exp_txn.pop_front();
            chk("txn", 96'(cur), 96'(e));
          end
          pend = 1'b1;
          pend_err = (obi_addr == err_addr);
          if (obi_addr == 32'h4) pend_data = (status_q.size() != 0) ? status_q.pop_front() : 32'h1;
          else if (obi_addr == 32'h10) pend_data = value_out;
          else pend_data = '0;
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t got, e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
        got = '{rsp_hit, rsp_data, rsp_err};
        if (exp_rsp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got %0h, required no response", got);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp", 96'(got), 96'(e));
        end
        rsp_count++;
      end
    end
  end

  task automatic push_txn(input logic [31:0] a, input logic we, input logic [31:0] d);
    exp_txn.push_back('{a, we, d});
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_ready_timeout: got 0 required 1");
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_val = val;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (rsp_count < target && t < 300) begin @(negedge clk); t++; end
    if (rsp_count < target) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got %0d responses required %0d", rsp_count, target);
    end
    @(negedge clk);
    chk("txn_left", 96'(exp_txn.size()), 96'(0));
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                     input rsp_t r);
    int target;
    target = rsp_count + 1;
    exp_rsp.push_back(r);
    issue(op, key, val);
    wait_rsp(target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 96'(cmd_ready), 96'(1));
    chk({tag, "_rsp"}, 96'({rsp_valid, rsp_hit, rsp_err, rsp_data}), 96'(0));
    chk({tag, "_obi"}, 96'({obi_req, obi_we, obi_addr, obi_wdata}), 96'(0));
  endtask

  initial begin
    int t;
    int base;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_val = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("reset");
    rst_n = 1'b1;

    // PUT, STATUS idle/miss
    push_txn(32'h08, 1'b1, 32'h2A); push_txn(32'h0C, 1'b1, 32'hDEAD_BEEF);
    push_txn(32'h00, 1'b1, 32'h2);  push_txn(32'h04, 1'b0, 32'h0);
    status_q.push_back(32'h0);
    run(2'd2, 32'h2A, 32'hDEAD_BEEF, '{1'b0, 32'h0, 1'b0});

    // GET hit after three busy polls
    push_txn(32'h08, 1'b1, 32'h2A); push_txn(32'h00, 1'b1, 32'h1);
    repeat (4) push_txn(32'h04, 1'b0, 32'h0);
    push_txn(32'h10, 1'b0, 32'h0);
    status_q.push_back(32'h1); status_q.push_back(32'h1); status_q.push_back(32'h1);
    status_q.push_back(32'h2);
    run(2'd1, 32'h2A, 32'h0, '{1'b1, 32'hDEAD_BEEF, 1'b0});

    // GET miss
    push_txn(32'h08, 1'b1, 32'h55); push_txn(32'h00, 1'b1, 32'h1); push_txn(32'h04, 1'b0, 32'h0);
    status_q.push_back(32'h0);
    run(2'd1, 32'h55, 32'h0, '{1'b0, 32'h0, 1'b0});

    // DEL hit: hit reported, no VALUE_OUT read
    push_txn(32'h08, 1'b1, 32'h2A); push_txn(32'h00, 1'b1, 32'h3); push_txn(32'h04, 1'b0, 32'h0);
    status_q.push_back(32'h2);
    run(2'd3, 32'h2A, 32'h0, '{1'b1, 32'h0, 1'b0});

    // Poll timeout at POLL_LIMIT=4
    push_txn(32'h08, 1'b1, 32'h1); push_txn(32'h00, 1'b1, 32'h1);
    repeat (4) push_txn(32'h04, 1'b0, 32'h0);
    repeat (4) status_q.push_back(32'h1);
    run(2'd1, 32'h1, 32'h0, '{1'b0, 32'h0, 1'b1});
    status_q.delete();

    // OBI error on KEY write with delayed grant
    gnt_delay = 5; err_addr = 32'h08;
    push_txn(32'h08, 1'b1, 32'h77);
    run(2'd1, 32'h77, 32'h0, '{1'b0, 32'h0, 1'b1});
    gnt_delay = 0; err_addr = 32'hFFFF_FFFF;

    // Reserved op: no OBI traffic
    run(2'd0, 32'h9, 32'h0, '{1'b0, 32'h0, 1'b1});

    // Backpressured response held stable
    rsp_ready = 1'b0;
    push_txn(32'h08, 1'b1, 32'h2A); push_txn(32'h00, 1'b1, 32'h1);
    push_txn(32'h04, 1'b0, 32'h0);  push_txn(32'h10, 1'b0, 32'h0);
    status_q.push_back(32'h2);
    exp_rsp.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
    base = rsp_count;
    issue(2'd1, 32'h2A, 32'h0);
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_rsp_valid_seen", 96'(rsp_valid), 96'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", 96'({rsp_valid, rsp_hit, rsp_err, rsp_data}), 96'({3'b110, 32'hDEAD_BEEF}));
      chk("bp_cmd_ready", 96'(cmd_ready), 96'(0));
    end
    rsp_ready = 1'b1;
    wait_rsp(base + 1);

    // Reset while a STATUS read is pending
    push_txn(32'h08, 1'b1, 32'h7); push_txn(32'h00, 1'b1, 32'h1);
    base = txn_count;
    issue(2'd1, 32'h7, 32'h0);
    t = 0;
    while (txn_count < base + 2 && t < 100) begin @(negedge clk); t++; end
    gnt_delay = 30;
    t = 0;
    while (!(obi_req && obi_addr == 32'h4) && t < 100) begin @(negedge clk); t++; end
    #1 chk("poll_req_pending", 96'({obi_req, obi_addr}), 96'({1'b1, 32'h4}));
    rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    chk("midreset_txn_left", 96'(exp_txn.size()), 96'(0));

    // Recovery after reset
    push_txn(32'h08, 1'b1, 32'h3C); push_txn(32'h00, 1'b1, 32'h1); push_txn(32'h04, 1'b0, 32'h0);
    status_q.push_back(32'h0);
    run(2'd1, 32'h3C, 32'h0, '{1'b0, 32'h0, 1'b0});
    chk("rsp_left", 96'(exp_rsp.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
